// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_pkg
// Description : Shared types, limits, FSM encoding and BCD helpers for the
//               time-of-day counter. Hour limits follow the build mode
//               selected by the TIME_12H_EN macro (defined = 12-hour mode).
// Revision    : 1.0 - initial release
// ============================================================================
package time_pkg;

  typedef logic [3:0] bcd_t;   // one BCD digit
  typedef logic [7:0] bcd2_t;  // packed pair: tens[7:4], ones[3:0]

  localparam bcd2_t SEC_MAX = 8'h59;
  localparam bcd2_t MIN_MAX = 8'h59;

`ifdef TIME_12H_EN
  localparam bcd2_t HOUR_MAX = 8'h12;
  localparam bcd2_t HOUR_MIN = 8'h01;
  localparam bcd2_t HOUR_RST = 8'h12;  // 12:00:00 AM
`else
  localparam bcd2_t HOUR_MAX = 8'h23;
  localparam bcd2_t HOUR_MIN = 8'h00;
  localparam bcd2_t HOUR_RST = 8'h00;  // 00:00:00
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Per-digit increment: ones wraps 9->0 and carries into tens. The caller
  // handles the field maximum.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd_t tens;
    bcd_t ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Both nibbles must be decimal digits; once they are, a packed-BCD value
  // orders the same way as its decimal value, so plain compares work.
  function automatic logic bcd2_in_range(input bcd2_t v, input bcd2_t lo, input bcd2_t hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Two-digit packed-BCD counter, 00..MAX, with enable,
//               synchronous load (priority over enable) and carry-out.
// Ports       : clk, reset_n (async, active-low)
//               en       - advance by one
//               load     - load load_val
//               q        - current value (registered)
//               carry    - en while q == MAX (wraps to 00 on this edge)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       carry
);

  bcd2_t r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (en) begin
      r_q <= (r_q == MAX) ? '0 : bcd2_inc(r_q);
    end
  end

  assign q     = r_q;
  assign carry = en && (r_q == MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_time_counter
// Description : Time-of-day counter (hh:mm:ss packed BCD) advanced by rising
//               edges of a synchronised 1 Hz input, with a validated preset
//               load over a valid/ready handshake.
//               Build macro TIME_12H_EN: defined = 12-hour mode with pm flag,
//               undefined = 24-hour mode (pm tied 0, set_pm ignored).
// Ports       : clk, reset_n (async, active-low)
//               tick_in              - 1 Hz square wave (data, not a clock)
//               run                  - 1 = count, 0 = hold (ticks discarded)
//               set_valid/set_ready  - load handshake
//               set_hh/mm/ss, set_pm - requested time
//               hh/mm/ss, pm         - current time (registered)
//               sec_pulse            - one cycle per seconds advance
//               rollover             - one cycle when the day wraps
//               set_err              - one cycle when a load is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       run,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       rollover,
  output logic       set_err
);

  // Synchroniser and edge detector. All flops reset high so a tick_in that
  // is already high when reset releases does not look like a rising edge.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   w_strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], tick_in};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_strobe = r_sync[SYNC_STAGES-1] & ~r_sync_d;

  // Load FSM
  state_t r_state;
  logic   r_set_ready;
  logic   r_set_err;
  logic   r_sec_pulse;
  bcd2_t  r_ld_hh;
  bcd2_t  r_ld_mm;
  bcd2_t  r_ld_ss;
  logic   w_handshake;
  logic   w_ld_ok;
  logic   w_commit;
  logic   w_advance;

  // r_set_ready is only high in IDLE, so this is also the IDLE->LOAD condition.
  assign w_handshake = set_valid & r_set_ready;
  assign w_ld_ok     = bcd2_in_range(r_ld_ss, 8'h00, SEC_MAX) &&
                       bcd2_in_range(r_ld_mm, 8'h00, MIN_MAX) &&
                       bcd2_in_range(r_ld_hh, HOUR_MIN, HOUR_MAX);
  assign w_commit    = (r_state == ST_LOAD) & w_ld_ok;
  // A load in progress (handshake or LOAD cycle) swallows the tick.
  assign w_advance   = w_strobe & run & (r_state == ST_IDLE) & ~w_handshake;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_set_ready <= 1'b1;
      r_set_err   <= 1'b0;
      r_sec_pulse <= 1'b0;
      r_ld_hh     <= '0;
      r_ld_mm     <= '0;
      r_ld_ss     <= '0;
    end else begin
      r_set_err   <= 1'b0;
      r_sec_pulse <= w_advance;
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_ld_hh     <= set_hh;
            r_ld_mm     <= set_mm;
            r_ld_ss     <= set_ss;
            r_set_ready <= 1'b0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_set_err   <= ~w_ld_ok;
          r_set_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_set_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Seconds and minutes
  logic w_ss_carry;
  logic w_mm_carry;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (w_advance),
    .load     (w_commit),
    .load_val (r_ld_ss),
    .q        (ss),
    .carry    (w_ss_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (w_ss_carry),
    .load     (w_commit),
    .load_val (r_ld_mm),
    .q        (mm),
    .carry    (w_mm_carry)
  );

  // Hours, pm and day rollover
  bcd2_t r_hh;
  logic  r_rollover;

`ifdef TIME_12H_EN
  logic r_ld_pm;
  logic r_pm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_pm <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_handshake) begin
      r_ld_pm <= set_pm;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hh       <= HOUR_RST;
      r_pm       <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      if (w_commit) begin
        r_hh <= r_ld_hh;
        r_pm <= r_ld_pm;
      end else if (w_mm_carry) begin
        if (r_hh == HOUR_MAX) begin
          r_hh <= HOUR_MIN;            // 12 -> 01, meridiem unchanged
        end else begin
          r_hh <= bcd2_inc(r_hh);
          if (r_hh == 8'h11) begin     // 11 -> 12 flips meridiem
            r_pm       <= ~r_pm;
            r_rollover <= r_pm;        // only PM -> AM ends the day
          end
        end
      end
    end
  end

  assign pm = r_pm;
`else
  logic w_unused_set_pm;
  assign w_unused_set_pm = set_pm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hh       <= HOUR_RST;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      if (w_commit) begin
        r_hh <= r_ld_hh;
      end else if (w_mm_carry) begin
        if (r_hh == HOUR_MAX) begin
          r_hh       <= HOUR_MIN;
          r_rollover <= 1'b1;
        end else begin
          r_hh <= bcd2_inc(r_hh);
        end
      end
    end
  end

  assign pm = 1'b0;
`endif

  assign hh        = r_hh;
  assign set_ready = r_set_ready;
  assign set_err   = r_set_err;
  assign sec_pulse = r_sec_pulse;
  assign rollover  = r_rollover;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_time_counter
// Description : Self-checking bench for bcd_time_counter. Time is modelled as
//               seconds-of-day and rendered to BCD (12- or 24-hour depending
//               on TIME_12H_EN) for comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       run = 1'b1;
  logic       set_valid = 1'b0;
  logic [7:0] set_hh = '0, set_mm = '0, set_ss = '0;
  logic       set_pm = 1'b0;
  logic       set_ready;
  logic [7:0] hh, mm, ss;
  logic       pm, sec_pulse, rollover, set_err;

  int checks = 0;
  int errors = 0;
  int t = 0;  // model: seconds since midnight

  always #5 clk = ~clk;

  bcd_time_counter #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_in   (tick_in),
    .run       (run),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .set_pm    (set_pm),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .pm        (pm),
    .sec_pulse (sec_pulse),
    .rollover  (rollover),
    .set_err   (set_err)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // {hh, mm, ss, pm} as the display should show it for a given second of day
  function automatic logic [24:0] model_time(input int secs);
    int h, m, s, hd;
    logic p;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
`ifdef TIME_12H_EN
    hd = (h % 12 == 0) ? 12 : h % 12;
    p  = (h >= 12);
`else
    hd = h;
    p  = 1'b0;
`endif
    return {to_bcd(hd), to_bcd(m), to_bcd(s), p};
  endfunction

  function automatic int bcd_val(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick_in period with random duty; counts pulses across the window.
  task automatic test_tick(input string name);
    int hi, lo, np, nr, exp_r, exp_p;
    logic [24:0] e;
    np = 0; nr = 0;
    hi = $urandom_range(1, 4);
    lo = $urandom_range(3, 6);
    exp_p = run ? 1 : 0;
    exp_r = (run && t == 86399) ? 1 : 0;
    if (run) t = (t + 1) % 86400;
    tick_in = 1'b1;
    repeat (hi) begin step(); np += int'(sec_pulse); nr += int'(rollover); end
    tick_in = 1'b0;
    repeat (lo) begin step(); np += int'(sec_pulse); nr += int'(rollover); end
    e = model_time(t);
    checks++;
    if ({hh, mm, ss, pm} !== e) begin
      errors++;
      $display("FAIL %s time: got %h:%h:%h pm=%b, expected %h:%h:%h pm=%b",
               name, hh, mm, ss, pm, e[24:17], e[16:9], e[8:1], e[0]);
    end
    checks++;
    if (np !== exp_p) begin
      errors++;
      $display("FAIL %s sec_pulse count: got %0d, expected %0d", name, np, exp_p);
    end
    checks++;
    if (nr !== exp_r) begin
      errors++;
      $display("FAIL %s rollover count: got %0d, expected %0d", name, nr, exp_r);
    end
  endtask

  task automatic test_load(input logic [7:0] h, m, s, input logic p, input string name);
    int hv, mv, sv, h24;
    bit ok;
    logic [24:0] e;
    hv = bcd_val(h); mv = bcd_val(m); sv = bcd_val(s);
`ifdef TIME_12H_EN
    ok  = (sv >= 0 && sv <= 59) && (mv >= 0 && mv <= 59) && (hv >= 1 && hv <= 12);
    h24 = (hv % 12) + (p ? 12 : 0);
`else
    ok  = (sv >= 0 && sv <= 59) && (mv >= 0 && mv <= 59) && (hv >= 0 && hv <= 23);
    h24 = hv;
`endif
    checks++;
    if (set_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready before load: got %b, expected 1", name, set_ready);
    end
    set_hh = h; set_mm = m; set_ss = s; set_pm = p; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    checks++;
    if (set_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready in load cycle: got %b, expected 0", name, set_ready);
    end
    step();
    if (ok) t = h24 * 3600 + mv * 60 + sv;
    e = model_time(t);
    checks++;
    if (set_ready !== 1'b1 || set_err !== !ok) begin
      errors++;
      $display("FAIL %s ready/err after load: got %b/%b, expected 1/%b", name, set_ready, set_err, !ok);
    end
    checks++;
    if ({hh, mm, ss, pm} !== e) begin
      errors++;
      $display("FAIL %s time after load: got %h:%h:%h pm=%b, expected %h:%h:%h pm=%b",
               name, hh, mm, ss, pm, e[24:17], e[16:9], e[8:1], e[0]);
    end
    step();
    checks++;
    if (set_err !== 1'b0) begin
      errors++;
      $display("FAIL %s set_err width: got %b, expected 0", name, set_err);
    end
  endtask

  task automatic test_reset();
    int np;
    logic [24:0] e;
    np = 0;
    tick_in = 1'b1;
    reset_n = 1'b0;
    repeat (3) step();
    e = model_time(0);
    checks++;
    if ({hh, mm, ss, pm} !== e) begin
      errors++;
      $display("FAIL reset time: got %h:%h:%h pm=%b, expected %h:%h:%h pm=%b",
               hh, mm, ss, pm, e[24:17], e[16:9], e[8:1], e[0]);
    end
    checks++;
    if ({set_ready, sec_pulse, rollover, set_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset flags: got rdy/sp/ro/err=%b%b%b%b, expected 1000",
               set_ready, sec_pulse, rollover, set_err);
    end
    reset_n = 1'b1;
    repeat (6) begin step(); np += int'(sec_pulse); end
    tick_in = 1'b0;
    repeat (4) begin step(); np += int'(sec_pulse); end
    checks++;
    if (np !== 0 || ss !== 8'h00) begin
      errors++;
      $display("FAIL reset high tick: got pulses=%0d ss=%h, expected 0 and 00", np, ss);
    end
    t = 0;
    repeat (3) test_tick("first_seconds");
    checks++;
    if (ss !== 8'h03) begin
      errors++;
      $display("FAIL three_seconds: got ss=%h, expected 03", ss);
    end
  endtask

  task automatic test_rollover();
`ifdef TIME_12H_EN
    test_load(8'h11, 8'h59, 8'h59, 1'b1, "load_1159pm");
    test_tick("pm_to_am");
    test_load(8'h12, 8'h59, 8'h59, 1'b0, "load_1259am");
    test_tick("12_to_01");
    test_load(8'h11, 8'h59, 8'h59, 1'b0, "load_1159am");
    test_tick("am_to_pm");
`else
    test_load(8'h23, 8'h59, 8'h58, 1'b0, "load_235958");
    test_tick("to_235959");
    test_tick("day_wrap");
    test_load(8'h09, 8'h59, 8'h59, 1'b0, "load_095959");
    test_tick("digit_carry");
`endif
  endtask

  task automatic test_invalid_load();
    test_load(8'h10, 8'h20, 8'h30, 1'b1, "good_load");
    test_load(8'h10, 8'h20, 8'h5A, 1'b0, "bad_ss_nibble");
    test_load(8'h24, 8'h00, 8'h00, 1'b0, "bad_hh_24");
    test_load(8'h10, 8'h60, 8'h00, 1'b0, "bad_mm_60");
    test_load(8'h00, 8'h10, 8'h10, 1'b0, "hh_00");
  endtask

  task automatic test_run_hold();
    run = 1'b0;
    repeat (5) test_tick("run_off");
    run = 1'b1;
    test_tick("run_resume");
    test_tick("run_resume2");
  endtask

  // Tick strobe lands in the handshake cycle (d=2) or LOAD cycle (d=1).
  task automatic test_load_collision();
    int secs, np;
    logic [24:0] v, e;
    for (int d = 1; d <= 2; d++) begin
      np = 0;
      secs = $urandom_range(0, 86399);
      v = model_time(secs);
      tick_in = 1'b1;
      repeat (d) step();
      set_hh = v[24:17]; set_mm = v[16:9]; set_ss = v[8:1]; set_pm = v[0];
      set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      repeat (6) begin step(); np += int'(sec_pulse); end
      tick_in = 1'b0;
      repeat (4) begin step(); np += int'(sec_pulse); end
      t = secs;
      e = model_time(t);
      checks++;
      if (np !== 0 || {hh, mm, ss, pm} !== e) begin
        errors++;
        $display("FAIL collision d=%0d: got pulses=%0d %h:%h:%h pm=%b, expected 0 %h:%h:%h pm=%b",
                 d, np, hh, mm, ss, pm, e[24:17], e[16:9], e[8:1], e[0]);
      end
      test_tick("after_collision");
    end
  endtask

  task automatic test_reset_mid_load();
    logic [24:0] e;
    set_hh = 8'h07; set_mm = 8'h45; set_ss = 8'h30; set_pm = 1'b1;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    t = 0;
    e = model_time(0);
    checks++;
    if ({hh, mm, ss, pm} !== e || set_ready !== 1'b1 || set_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load: got %h:%h:%h pm=%b rdy=%b err=%b, expected %h:%h:%h pm=%b rdy=1 err=0",
               hh, mm, ss, pm, set_ready, set_err, e[24:17], e[16:9], e[8:1], e[0]);
    end
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if ({hh, mm, ss, pm} !== e || set_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load after release: got %h:%h:%h pm=%b err=%b, expected %h:%h:%h pm=%b err=0",
               hh, mm, ss, pm, set_err, e[24:17], e[16:9], e[8:1], e[0]);
    end
    test_tick("after_reset_load");
  endtask

  task automatic test_random();
    logic [24:0] v;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: begin
          v = model_time($urandom_range(0, 86399));
          test_load(v[24:17], v[16:9], v[8:1], v[0], "rand_valid_load");
        end
        1: test_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand_raw_load");
        2: begin
          // park near a minute/hour/day boundary to exercise carries
          v = model_time((($urandom_range(0, 23) * 3600) + 3599 - $urandom_range(0, 2)));
          test_load(v[24:17], v[16:9], v[8:1], v[0], "rand_edge_load");
        end
        default: begin
          run = ($urandom_range(0, 4) != 0);
          test_tick("rand_tick");
        end
      endcase
    end
    run = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_invalid_load();
    test_run_hold();
    test_load_collision();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day counter that consumes the 1 Hz square wave produced by the cascaded-BCD clock divider and maintains hours, minutes and seconds as packed BCD. Runs on the same clock as the divider's input clock. The 1 Hz input is treated as data: it is synchronised and edge-detected, never used as a clock. Supports a presettable time load over a valid/ready handshake, and drives display and alarm logic downstream.

## Interface
- SYNC_STAGES, 2, flops in the tick_in synchroniser (≥2)
- clk  in  1  system clock (1 kHz divider input clock)
- reset_n  in  1  asynchronous, active-low reset
- tick_in  in  1  1 Hz square wave from divider; each rising edge = one second
- run  in  1  1 = count seconds; 0 = hold time, discard ticks
- set_valid  in  1  load request
- set_ready  out  1  load request accepted when set_valid & set_ready
- set_hh, set_mm, set_ss  in  8 each  requested time, packed BCD (tens[7:4], ones[3:0])
- set_pm  in  1  PM flag for load (12-hour build only; ignored otherwise)
- hh, mm, ss  out  8 each  current time, packed BCD
- pm  out  1  PM indicator (12-hour build); constant 0 otherwise
- sec_pulse  out  1  one-cycle pulse on every seconds advance
- rollover  out  1  one-cycle pulse when the day wraps
- set_err  out  1  one-cycle pulse when a load is rejected as invalid

## Operation
- Reset (async, reset_n=0) values:
  - ss=mm=00.
  - hh=00 (24 h) or 12 with pm=0 (12 h).
  - set_ready=1; sec_pulse=rollover=set_err=0.
  - All synchroniser and edge-detect flops =1, so a tick_in held high across reset release gives no advance.
- Edge detect: the advance strobe is asserted when the last sync stage =1 and its delayed copy =0.
- FSM:
  - IDLE: set_ready=1. Handshake → LOAD. Advance strobe with run=1 → advance time.
  - LOAD (one cycle): set_ready=0.
    - Validate set_* values.
    - If valid, commit them to hh/mm/ss/pm.
    - If invalid, pulse set_err and leave time unchanged.
    - Always → IDLE.
- Validity rules:
  - Every BCD nibble ≤9.
  - ss, mm ≤59.
  - hh ≤23 (24 h) or hh in 01..12 (12 h).
- Advance:
  - ss+1. 59→00 carries to mm.
  - mm 59→00 carries to hh.
  - 24 h: 23→00 and pulse rollover.
  - 12 h: 11→12 toggles pm and pulses rollover only on the PM→AM transition; 12→01 with no pm change.
- Arithmetic: per-digit BCD. The ones digit wraps 9→0 with carry into tens; the tens digit wraps at its field maximum.
- run=0: the synchroniser keeps tracking, advance strobes are dropped, time holds. Loads are still accepted.
- Simultaneous events: an advance strobe in the LOAD cycle, or in the handshake cycle, is dropped. Load wins.

## Timing
- tick_in rise sampled at edge k: strobe is high in the cycle after edge k+SYNC_STAGES−1. ss, sec_pulse and rollover update at edge k+SYNC_STAGES.
- Load: handshake at edge n. New time (or set_err) is visible after edge n+1. set_ready returns high after edge n+1.
- Minimum spacing between accepted loads: 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- reset_n assertion mid-operation clears everything immediately, including an in-flight LOAD.

## Configuration
- TIME_12H_EN defined:
  - 12-hour mode; hh range 01..12; pm active.
  - set_pm is loaded with the time.
  - Reset time is 12:00:00 AM.
- TIME_12H_EN undefined:
  - 24-hour mode; hh range 00..23.
  - pm tied 0; set_pm unused.
  - Reset time is 00:00:00.

## Structure
- Package time_pkg holds:
  - the bcd_t (4-bit) and bcd2_t (8-bit packed) typedefs;
  - constants SEC_MAX=8'h59 and MIN_MAX=8'h59;
  - HOUR_MAX and HOUR_MIN for each mode;
  - HOUR_RST for each mode;
  - the FSM state enum.
- Sub-module bcd_mod_counter:
  - two-digit BCD counter with parameterised maximum, enable, synchronous load and carry-out;
  - instantiated for ss and mm.
- Hours and pm logic stay in the top level.

## Test plan
- Reset with tick_in held high, release, 3 s of ticks → ss=03, no extra advance, sec_pulse ×3.
- Load 23:59:58 (24 h), 2 ticks → 23:59:59, then 00:00:00 with a single rollover pulse.
- TIME_12H_EN: load 11:59:59 PM, 1 tick → 12:00:00, pm=0, rollover. Load 12:59:59 AM, 1 tick → 01:00:00, pm=0.
- Load ss=8'h5A, then hh=8'h24 (24 h) → set_err pulse each time; time unchanged; set_ready low exactly one cycle per load.
- run=0 for 5 ticks → time frozen. run=1 → resumes at the next tick rise.
- Tick strobe aligned with the LOAD cycle → loaded value shown, that tick dropped. Assert reset_n mid-LOAD → reset values immediately.
